// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Types and constants shared by the radix-4 Booth multiplier.
//   mult_state_e  : control FSM states (IDLE, RUN, DONE)
//   booth_digit_e : recoded radix-4 Booth digit, one of {0, +1, +2, -1, -2}
//   DEFAULT_WIDTH : default operand width of booth_multiplier
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

endpackage : mult_pkg

// File: rtl/booth_radix4_recoder.sv
// ---------------------------------------------------------------------------
// booth_radix4_recoder
// Combinational radix-4 Booth recoder.
// Maps the triplet {b[2i+1], b[2i], b[2i-1]} onto a digit in {-2,-1,0,+1,+2}.
//   triplet : input  [2:0]  multiplier bits, MSB first
//   digit   : output        recoded Booth digit
// ---------------------------------------------------------------------------
module booth_radix4_recoder
  import mult_pkg::*;
(
  input  logic [2:0]   triplet,
  output booth_digit_e digit
);

  // Standard radix-4 Booth table: digit = -2*b[2i+1] + b[2i] + b[2i-1]
  always_comb begin
    digit = ZERO;
    case (triplet)
      3'b000:  digit = ZERO;
      3'b001:  digit = POS1;
      3'b010:  digit = POS1;
      3'b011:  digit = POS2;
      3'b100:  digit = NEG2;
      3'b101:  digit = NEG1;
      3'b110:  digit = NEG1;
      3'b111:  digit = ZERO;
      default: digit = ZERO;
    endcase
  end

endmodule : booth_radix4_recoder

// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
// Iterative signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiplier using radix-4
// Booth recoding, one Booth digit per cycle, valid/ready on both sides.
//   clk          : input         rising-edge clock
//   rst_n        : input         asynchronous active-low reset
//   in_valid     : input         operands present
//   in_ready     : output        operands can be accepted (IDLE only)
//   is_signed    : input         1: two's-complement operands, 0: unsigned
//   multiplicand : input  WIDTH  operand A
//   multiplier   : input  WIDTH  operand B
//   out_valid    : output        product valid, held until accepted
//   out_ready    : input         consumer accepts product
//   product      : output 2*W    A x B
// ---------------------------------------------------------------------------
module booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int STEPS = WIDTH / 2 + 1;
  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int CNT_W = $clog2(STEPS + 1);

  // Two guard bits let an unsigned operand be treated as a positive signed
  // value, so a single signed Booth datapath serves both modes.
  function automatic logic [EXT_W-1:0] extend(input logic [WIDTH-1:0] v,
                                              input logic           sgn);
    logic ext_bit;
    ext_bit = sgn & v[WIDTH-1];
    return {{2{ext_bit}}, v};
  endfunction

  mult_state_e        state, state_next;
  logic [EXT_W-1:0]   a_ext, a_ext_next;
  // Multiplier with an appended 0 below the LSB, supplying b[-1].
  logic [EXT_W:0]     b_ext, b_ext_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [2*WIDTH-1:0] product_next;
  logic               in_ready_next;
  logic               out_valid_next;

  logic [CNT_W:0]     shamt;
  logic [2:0]         triplet;
  booth_digit_e       digit;
  logic [ACC_W-1:0]   a_wide;
  logic [ACC_W-1:0]   mag;
  logic               neg;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   carry;
  logic [ACC_W-1:0]   sum;

  assign shamt   = {cnt, 1'b0};
  assign triplet = 3'(b_ext >> shamt);
  assign a_wide  = {{(ACC_W-EXT_W){a_ext[EXT_W-1]}}, a_ext};

  booth_radix4_recoder u_recoder (
    .triplet (triplet),
    .digit   (digit)
  );

  // Partial-product selection: magnitude (A or 2A) plus a negate flag.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (digit)
      ZERO: begin mag = '0;            neg = 1'b0; end
      POS1: begin mag = a_wide;        neg = 1'b0; end
      POS2: begin mag = a_wide << 1;   neg = 1'b0; end
      NEG1: begin mag = a_wide;        neg = 1'b1; end
      NEG2: begin mag = a_wide << 1;   neg = 1'b1; end
      default: begin mag = '0;         neg = 1'b0; end
    endcase
  end

  // Negation as ~x + 1 folded into the accumulate adder; shifting both the
  // inverted term and the +1 by 2i equals shifting the negated value.
  always_comb begin
    addend = (neg ? ~mag : mag) << shamt;
    carry  = {{(ACC_W-1){1'b0}}, neg} << shamt;
    sum    = acc + addend + carry;
  end

  // Control FSM next-state and registered-output next values.
  always_comb begin
    state_next     = state;
    a_ext_next     = a_ext;
    b_ext_next     = b_ext;
    acc_next       = acc;
    cnt_next       = cnt;
    product_next   = product;
    in_ready_next  = in_ready;
    out_valid_next = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_ext_next    = extend(multiplicand, is_signed);
          b_ext_next    = {extend(multiplier, is_signed), 1'b0};
          acc_next      = '0;
          cnt_next      = '0;
          in_ready_next = 1'b0;
          state_next    = RUN;
        end else begin
          state_next    = IDLE;
        end
      end
      RUN: begin
        // One extra cycle after the last digit moves the sum into product.
        if (cnt == CNT_W'(STEPS)) begin
          product_next   = acc[2*WIDTH-1:0];
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          acc_next       = sum;
          cnt_next       = cnt + CNT_W'(1);
          state_next     = RUN;
        end
      end
      DONE: begin
        // in_ready rises only after the handoff edge, so no new operands
        // are taken in the same cycle the product leaves.
        if (out_ready) begin
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          state_next     = IDLE;
        end else begin
          state_next     = DONE;
        end
      end
      default: begin
        out_valid_next = 1'b0;
        in_ready_next  = 1'b1;
        state_next     = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_ext     <= '0;
      b_ext     <= '0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      a_ext     <= a_ext_next;
      b_ext     <= b_ext_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      product   <= product_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
    end
  end

endmodule : booth_multiplier

// File: tb/tb_booth_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier
// Directed and randomised checks of booth_multiplier (WIDTH = 32).
// ---------------------------------------------------------------------------
module tb_booth_multiplier;

  localparam int W   = 32;
  localparam int LAT = W / 2 + 2;   // STEPS + 1 edges from accept to out_valid

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          is_signed;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] product;

  int checks;
  int passes;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for out_valid; lat counts rising edges since the accept.
  task automatic wait_done(output int lat, output bit ir_seen, output bit timeout);
    lat = 0;
    ir_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    timeout = !out_valid;
  endtask

  // Presents one operand pair for one edge, then scrambles the inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    is_signed    = s;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid     = 1'b0;
    multiplicand = 32'hDEAD_BEEF;
    multiplier   = 32'h1234_5678;
    is_signed    = ~s;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2*W-1:0] p, output int lat,
                        output bit ir_seen, output bit timeout);
    issue(a, b, s);
    wait_done(lat, ir_seen, timeout);
    p = product;
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else passes++;
    checks++;
    if (product !== 64'h0) $display("FAIL reset_product got %h want 0", product);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_signed();
    logic [2*W-1:0] p;
    int lat;
    bit ir, to;
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, p, lat, ir, to);
    checks++;
    if (to) $display("FAIL signed_timeout no out_valid within %0d edges", lat);
    else passes++;
    checks++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL signed_7x-3 got %h want ffffffffffffffeb", p);
    else passes++;
    checks++;
    if (lat !== LAT) $display("FAIL signed_latency got %0d want %0d", lat, LAT);
    else passes++;
    checks++;
    if (ir !== 1'b0) $display("FAIL signed_in_ready_during_run got 1 want 0");
    else passes++;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL signed_in_ready_in_done got %b want 0", in_ready);
    else passes++;
    take();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL signed_handoff got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_signed_corner();
    logic [2*W-1:0] p;
    int lat;
    bit ir, to;
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, p, lat, ir, to);
    checks++;
    if (p !== 64'h4000_0000_0000_0000) $display("FAIL signed_min_x_min got %h want 4000000000000000", p);
    else passes++;
    take();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, lat, ir, to);
    checks++;
    if (p !== 64'h0000_0000_0000_0001) $display("FAIL signed_m1_x_m1 got %h want 1", p);
    else passes++;
    take();
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, p, lat, ir, to);
    checks++;
    if (p !== 64'hFFFF_FFFF_8000_0000) $display("FAIL signed_min_x_1 got %h want ffffffff80000000", p);
    else passes++;
    take();
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] p;
    int lat;
    bit ir, to;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, ir, to);
    checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001) $display("FAIL unsigned_max_x_max got %h want fffffffe00000001", p);
    else passes++;
    take();
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, p, lat, ir, to);
    checks++;
    if (p !== 64'h0000_0001_FFFF_FFFE) $display("FAIL unsigned_max_x_2 got %h want 00000001fffffffe", p);
    else passes++;
    take();
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, p, lat, ir, to);
    checks++;
    if (p !== 64'h0000_0000_8000_0000) $display("FAIL unsigned_msb_x_1 got %h want 80000000", p);
    else passes++;
    take();
  endtask

  task automatic test_back_pressure();
    logic [2*W-1:0] p;
    int lat, bad;
    bit ir, to;
    run_op(32'h0001_0000, 32'h0000_0100, 1'b1, p, lat, ir, to);
    checks++;
    if (p !== 64'h0000_0000_0100_0000) $display("FAIL bp_product got %h want 0000000001000000", p);
    else passes++;
    // Offer new operands while the consumer stalls.
    @(negedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    is_signed    = 1'b0;
    in_valid     = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || product !== 64'h0000_0000_0100_0000 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold cycle %0d got out_valid=%b in_ready=%b product=%h want 1/0/0000000001000000",
                 i, out_valid, in_ready, product);
        bad++;
      end
    end
    checks++;
    if (bad == 0) passes++;
    // Handoff with in_valid still high: must not be accepted in DONE.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else passes++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_next_accept got in_ready=%b want 0", in_ready);
    else passes++;
    wait_done(lat, ir, to);
    checks++;
    if (product !== 64'd81 || lat !== LAT)
      $display("FAIL bp_next_result got %h lat %0d want 0000000000000051 lat %0d", product, lat, LAT);
    else passes++;
    take();
  endtask

  task automatic test_reset_mid_run();
    logic [2*W-1:0] p;
    int lat;
    bit ir, to;
    issue(32'h0000_0100, 32'h0000_0100, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || product !== 64'h0 || in_ready !== 1'b1)
      $display("FAIL rst_run got out_valid=%b product=%h in_ready=%b want 0/0/1", out_valid, product, in_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd5, 1'b1, p, lat, ir, to);
    checks++;
    if (p !== 64'd15) $display("FAIL rst_run_then_3x5 got %h want 000000000000000f", p);
    else passes++;
    // Reset while the result is waiting in DONE discards it.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || product !== 64'h0 || in_ready !== 1'b1)
      $display("FAIL rst_done got out_valid=%b product=%h in_ready=%b want 0/0/1", out_valid, product, in_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] p, expv;
    int lat;
    bit ir, to;
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      b = $urandom;
      if (n % 7 == 0) a = {1'b1, 31'($urandom_range(0, 3))};
      s = 1'($urandom_range(0, 1));
      if (s) expv = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      else   expv = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      run_op(a, b, s, p, lat, ir, to);
      checks++;
      if (to || p !== expv || lat !== LAT)
        $display("FAIL random_%0d a=%h b=%h s=%b got %h lat %0d want %h lat %0d",
                 n, a, b, s, p, lat, expv, LAT);
      else passes++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      take();
    end
  endtask

  initial begin
    checks       = 0;
    passes       = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    is_signed    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    out_ready    = 1'b0;
    test_reset();
    test_signed();
    test_signed_corner();
    test_unsigned();
    test_back_pressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_booth_multiplier
